uart_cmd_rx: RTL

Host-to-FPGA command receiver for the oscilloscope control path, on the opposite wire from the ADC sample transmitter. It deserialises 8N1 UART bytes from the host's `uart_rx` line and parses 5-byte command frames. Each good frame produces a one-cycle register-write strobe (address plus 16-bit data) for downstream control logic such as trigger level, sample rate and run/stop.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 86 ++++++++
 rtl/uart_cmd_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state types for the UART command receiver
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        DHI,
        DLO,
        CHK
    } parseState_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with input synchroniser
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(DELAY_FRAMES + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);

    logic             rxMeta;
    logic             rxSync;
    rxState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta     <= 1'b1;
            rxSync     <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rxMeta     <= uart_rx;
            rxSync     <= rxMeta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxSync) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= rxSync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        shiftReg <= {rxSync, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        // Back to IDLE in the sample cycle so a zero-gap start edge is caught
                        cnt   <= '0;
                        state <= IDLE;
                        if (rxSync) begin
                            byte_data  <= shiftReg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - parses A5/ADDR/DHI/DLO/CHK frames into register-write strobes
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = 234,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic        chk_err,
    output logic        timeout
);

    localparam int TO_LIMIT = TIMEOUT_BITS * DELAY_FRAMES;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    parseState_t      pState;
    logic [7:0]       addrReg;
    logic [7:0]       dhiReg;
    logic [7:0]       dloReg;
    logic [TO_W-1:0]  toCnt;

    uart_rx_byte #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_rx_byte (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pState    <= HUNT;
            addrReg   <= '0;
            dhiReg    <= '0;
            dloReg    <= '0;
            toCnt     <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            chk_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            timeout   <= 1'b0;
            if (frame_err) begin
                pState <= HUNT;
                toCnt  <= '0;
            end else if (byte_valid) begin
                // A byte landing on the expiry cycle wins over the timeout
                toCnt <= '0;
                case (pState)
                    HUNT: if (byte_data == SYNC_BYTE) pState <= ADDR;
                    ADDR: begin
                        addrReg <= byte_data;
                        pState  <= DHI;
                    end
                    DHI: begin
                        dhiReg <= byte_data;
                        pState <= DLO;
                    end
                    DLO: begin
                        dloReg <= byte_data;
                        pState <= CHK;
                    end
                    CHK: begin
                        if (byte_data == (addrReg ^ dhiReg ^ dloReg)) begin
                            cmd_addr  <= addrReg;
                            cmd_data  <= {dhiReg, dloReg};
                            cmd_valid <= 1'b1;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        pState <= HUNT;
                    end
                    default: pState <= HUNT;
                endcase
            end else if (pState != HUNT) begin
                if (toCnt == TO_W'(TO_LIMIT)) begin
                    timeout <= 1'b1;
                    pState  <= HUNT;
                    toCnt   <= '0;
                end else begin
                    toCnt <= toCnt + TO_W'(1);
                end
            end else begin
                toCnt <= '0;
            end
        end
    end

endmodule
